// File: rtl/orb_pkg.sv
// orb_pkg: orbit-RAM widths, write-slot entry type and the round-robin picker
// shared by orb_wr_arbiter and orb_wr_slot.
package orb_pkg;

   localparam int ORB_ADDR_W = 11;
   localparam int ORB_WORD_W = 12;

   typedef struct packed {
      logic [ORB_ADDR_W-1:0] addr;
      logic [ORB_WORD_W-1:0] data;
      logic                  bank;
   } orb_wr_t;

   localparam int ORB_ENTRY_W = $bits(orb_wr_t);

   // Returns {hit, index}: first valid bit at or after ptr, wrapping modulo n (n <= 8).
   function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
      logic [3:0] r;
      logic [2:0] idx;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         idx = 3'((int'(ptr) + i) % n);
         if (i < n && valid[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

endpackage

// File: rtl/orb_wr_slot.sv
// orb_wr_slot: one-entry holding slot for a single producer's write strobe;
// the bank tag is latched from the reader select at capture time.
module orb_wr_slot
   import orb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cap_i,
   input  logic                   gnt_i,
   input  logic                   sw_i,
   input  logic [ORB_ADDR_W-1:0]  addr_i,
   input  logic [ORB_WORD_W-1:0]  data_i,
   output logic                   valid_o,
   output logic [ORB_ENTRY_W-1:0] entry_o,
   output logic                   drop_o
);

   logic    valid_q;
   orb_wr_t entry_q;
   logic    load;

   // A slot being drained this cycle can accept the new strobe.
   assign load    = cap_i & (~valid_q | gnt_i);
   assign drop_o  = cap_i & valid_q & ~gnt_i;
   assign valid_o = valid_q;
   assign entry_o = entry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         entry_q <= '{addr: addr_i, data: data_i, bank: ~sw_i};
      end else if (gnt_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/orb_wr_arbiter.sv
// orb_wr_arbiter: round-robin sharing of the ping-pong orbit RAMs between N_REQ producers.
// Define ORB_WR_STATS_EN to add saturating per-requester drop counters (drop_cnt_o).
module orb_wr_arbiter
   import orb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = ORB_ADDR_W,
   parameter int WORD_W = ORB_WORD_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*ADDR_W-1:0] addr_i,
   input  logic [N_REQ*WORD_W-1:0] data_i,
   input  logic                    sw_i,
   input  logic                    ovf_clr_i,
   output logic                    wr_en0_o,
   output logic                    wr_en1_o,
   output logic [ADDR_W-1:0]       wr_addr_o,
   output logic [WORD_W-1:0]       wr_data_o,
   output logic                    busy_o,
   output logic [N_REQ-1:0]        ovf_o
`ifdef ORB_WR_STATS_EN
   ,
   output logic [N_REQ*8-1:0]      drop_cnt_o
`endif
);

   logic [N_REQ-1:0]       valid, gnt, drop, valid_d, ovf_q;
   logic [ORB_ENTRY_W-1:0] entry [N_REQ];
   logic [3:0]             pick;
   logic [2:0]             ptr_q, ptr_d;
   orb_wr_t                sel;
   logic                   en0_q, en1_q, busy_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [WORD_W-1:0]      data_q;

   for (genvar k = 0; k < N_REQ; k++) begin : g_slot
      assign gnt[k] = pick[3] & (pick[2:0] == 3'(k));
      orb_wr_slot u_slot (
         .clk     (clk),
         .rst     (rst),
         .cap_i   (req_i[k]),
         .gnt_i   (gnt[k]),
         .sw_i    (sw_i),
         .addr_i  (addr_i[k*ADDR_W +: ADDR_W]),
         .data_i  (data_i[k*WORD_W +: WORD_W]),
         .valid_o (valid[k]),
         .entry_o (entry[k]),
         .drop_o  (drop[k])
      );
`ifdef ORB_WR_STATS_EN
      logic [7:0] cnt_q;
      // An increment on the clear cycle still counts the new drop.
      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else if (drop[k]) cnt_q <= (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
         else if (ovf_clr_i) cnt_q <= '0;
      end
      assign drop_cnt_o[k*8 +: 8] = cnt_q;
`endif
   end

   always_comb begin
      pick = rr_pick(8'(valid), ptr_q, N_REQ);
      sel  = '0;
      for (int k = 0; k < N_REQ; k++)
         if (gnt[k]) sel = orb_wr_t'(entry[k]);
      ptr_d   = pick[3] ? ((pick[2:0] == 3'(N_REQ-1)) ? 3'd0 : pick[2:0] + 3'd1) : ptr_q;
      valid_d = req_i | (valid & ~gnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         en0_q  <= 1'b0;
         en1_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= 1'b0;
         ovf_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         en0_q  <= pick[3] & ~sel.bank;
         en1_q  <= pick[3] & sel.bank;
         if (pick[3]) begin
            addr_q <= sel.addr;
            data_q <= sel.data;
         end
         busy_q <= |valid_d;
         ovf_q  <= (ovf_clr_i ? '0 : ovf_q) | drop;
      end
   end

   assign wr_en0_o  = en0_q;
   assign wr_en1_o  = en1_q;
   assign wr_addr_o = addr_q;
   assign wr_data_o = data_q;
   assign busy_o    = busy_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// tb_orb_wr_arbiter: table-driven single writes plus hand-written contention sequences;
// expected writes are queued with their due cycle and matched as the DUT emits them.
module tb_orb_wr_arbiter;

   localparam int N = 3;

   typedef struct {
      logic [1:0]  en;
      logic [10:0] addr;
      logic [11:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [1:0]  k;
      logic [10:0] addr;
      logic [11:0] data;
      logic        sw;
      logic [1:0]  en;
      logic [10:0] ea;
      logic [11:0] ed;
   } vec_t;

   logic          clk = 1'b0, rst = 1'b1, sw = 1'b0, ovf_clr = 1'b0;
   logic [N-1:0]  req = '0;
   logic [10:0]   a_w [N];
   logic [11:0]   d_w [N];
   logic          wr_en0, wr_en1, busy;
   logic [10:0]   wr_addr;
   logic [11:0]   wr_data;
   logic [N-1:0]  ovf;
`ifdef ORB_WR_STATS_EN
   logic [N*8-1:0] drop_cnt;
`endif
   int  cyc = 0, n_vec = 0, n_err = 0;
   wr_t sbq[$];

   orb_wr_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req),
      .addr_i    ({a_w[2], a_w[1], a_w[0]}),
      .data_i    ({d_w[2], d_w[1], d_w[0]}),
      .sw_i      (sw),
      .ovf_clr_i (ovf_clr),
      .wr_en0_o  (wr_en0),
      .wr_en1_o  (wr_en1),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data),
      .busy_o    (busy),
      .ovf_o     (ovf)
`ifdef ORB_WR_STATS_EN
      ,
      .drop_cnt_o(drop_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic push(input logic [1:0] en, input logic [10:0] a, input logic [11:0] d, input int c);
      wr_t e;
      e = '{en: en, addr: a, data: d, cyc: c};
      sbq.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sbq.size()), 64'(0));
   endtask

   // Write monitor: every enable must match the queue head, at its due cycle.
   always @(negedge clk) begin
      wr_t e;
      if (wr_en0 || wr_en1) begin
         if (sbq.size() == 0) chk("unexpected_write", 64'({wr_en1, wr_en0, wr_addr, wr_data}), 64'(0));
         else begin
            e = sbq.pop_front();
            chk("write", {23'd0, wr_en1, wr_en0, wr_addr, wr_data, 16'(cyc)},
                {23'd0, e.en, e.addr, e.data, 16'(e.cyc)});
         end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         chk("missing_write", 64'(0), 64'(e.en));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt [6];
      int   c;
      vt = '{
         '{2'd0, 11'h005, 12'hABC, 1'b0, 2'b10, 11'h005, 12'hABC},
         '{2'd1, 11'h7FF, 12'hFFF, 1'b1, 2'b01, 11'h7FF, 12'hFFF},
         '{2'd2, 11'h000, 12'h000, 1'b0, 2'b10, 11'h000, 12'h000},
         '{2'd0, 11'h400, 12'h800, 1'b1, 2'b01, 11'h400, 12'h800},
         '{2'd1, 11'h2AA, 12'h555, 1'b0, 2'b10, 11'h2AA, 12'h555},
         '{2'd2, 11'h123, 12'h456, 1'b1, 2'b01, 11'h123, 12'h456}
      };
      foreach (a_w[i]) begin
         a_w[i] = '0;
         d_w[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_en0", 64'(wr_en0), 64'(0));
      chk("rst_en1", 64'(wr_en1), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ovf", 64'(ovf), 64'(0));
      chk("rst_addr_data", 64'({wr_addr, wr_data}), 64'(0));
      rst = 1'b0;

      // Single uncontended writes: enable two cycles after the strobe.
      foreach (vt[i]) begin
         @(negedge clk);
         a_w[vt[i].k] = vt[i].addr;
         d_w[vt[i].k] = vt[i].data;
         sw  = vt[i].sw;
         req = 3'b001 << vt[i].k;
         push(vt[i].en, vt[i].ea, vt[i].ed, cyc + 2);
         @(negedge clk);
         req = '0;
         chk("single_busy", 64'(busy), 64'(1));
         repeat (3) @(negedge clk);
      end

      // Simultaneous strobes with pointer at 0: writes in order 0,1,2.
      @(negedge clk);
      a_w = '{11'h010, 11'h020, 11'h030};
      d_w = '{12'h101, 12'h202, 12'h303};
      sw  = 1'b0;
      req = 3'b111;
      c   = cyc;
      push(2'b10, 11'h010, 12'h101, c + 2);
      push(2'b10, 11'h020, 12'h202, c + 3);
      push(2'b10, 11'h030, 12'h303, c + 4);
      @(negedge clk);
      req = '0;
      repeat (2) @(negedge clk);
      chk("sim_busy_mid", 64'(busy), 64'(1));
      @(negedge clk);
      chk("sim_busy_end", 64'(busy), 64'(0));
      chk("sim_ovf", 64'(ovf), 64'(0));
      drain();

      // Bank tag latched at capture despite a later sw_i edge.
      @(negedge clk);
      a_w[2] = 11'h0AB;
      d_w[2] = 12'hCDE;
      sw  = 1'b1;
      req = 3'b100;
      push(2'b01, 11'h0AB, 12'hCDE, cyc + 2);
      @(negedge clk);
      req = '0;
      sw  = 1'b0;
      drain();

      // Overflow on slot 2 while slots 0 and 1 are ahead of it.
      @(negedge clk);
      a_w = '{11'h100, 11'h101, 11'h102};
      d_w = '{12'h111, 12'h222, 12'h333};
      req = 3'b111;
      c   = cyc;
      push(2'b10, 11'h100, 12'h111, c + 2);
      push(2'b10, 11'h101, 12'h222, c + 3);
      push(2'b10, 11'h102, 12'h333, c + 4);
      @(negedge clk);
      req    = 3'b100;
      a_w[2] = 11'h1FF;
      d_w[2] = 12'hFFF;
      @(negedge clk);
      req = '0;
      chk("ovf_set", 64'(ovf), 64'(3'b100));
`ifdef ORB_WR_STATS_EN
      chk("drop_cnt", 64'(drop_cnt), 64'(24'h010000));
`endif
      drain();
      chk("ovf_sticky", 64'(ovf), 64'(3'b100));
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_clr", 64'(ovf), 64'(0));
`ifdef ORB_WR_STATS_EN
      chk("drop_cnt_clr", 64'(drop_cnt), 64'(0));
`endif

      // Fairness: 0 and 1 strobing every cycle alternate grants.
      @(negedge clk);
      a_w[0] = 11'h050;
      d_w[0] = 12'h0A0;
      a_w[1] = 11'h051;
      d_w[1] = 12'h0A1;
      c = cyc;
      for (int i = 0; i < 7; i++)
         if (i % 2 == 0) push(2'b10, 11'h050, 12'h0A0, c + 2 + i);
         else push(2'b10, 11'h051, 12'h0A1, c + 2 + i);
      for (int i = 0; i < 6; i++) begin
         req = 3'b011;
         @(negedge clk);
      end
      req = '0;
      drain();
      chk("fair_ovf", 64'(ovf), 64'(3'b011));

      // Reset with all three slots pending discards them.
      @(negedge clk);
      req = 3'b111;
      @(negedge clk);
      req = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_en", 64'({wr_en1, wr_en0}), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_ovf", 64'(ovf), 64'(0));
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'(0));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
